// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    ST_IDLE            = 2'd0,
    ST_CONFIRM_PRESS   = 2'd1,
    ST_PRESSED         = 2'd2,
    ST_CONFIRM_RELEASE = 2'd3
  } state_e;

  // Columns are active low; column 0 is driven first after reset
  localparam logic [3:0] COL_RESET = 4'b1110;

  // Rows are active low with pull-ups, so "nothing pressed" reads all ones
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // Code reported alongside cand_ok=0 (no key, or an ambiguous multi-press)
  localparam logic [3:0] CODE_NONE = 4'h0;

  // Key legend indexed [row][col], matching the Pmod KYPD silkscreen
  localparam logic [3:0] KEY_CODE [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  // Position of switch (c,r) inside the 16-bit press snapshot
  function automatic logic [3:0] snap_idx(input logic [1:0] c, input logic [1:0] r);
    return {c, r};
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Turns one committed 16-bit press snapshot into a single-key candidate.
// Anything other than exactly one closed switch (idle pad, multi-press,
// ghosting) is reported as "no candidate".
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [15:0] snap_i,
  output logic        cand_ok_o,
  output logic [3:0]  cand_o
);

  logic [4:0] hits;
  logic [3:0] hit_code;

  // Count closed switches and remember the legend of the last one found
  always_comb begin
    hits     = '0;
    hit_code = CODE_NONE;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (snap_i[snap_idx(2'(c), 2'(r))]) begin
          hits     = hits + 5'd1;
          hit_code = KEY_CODE[r][c];
        end
      end
    end
  end

  // Only an unambiguous single press produces a candidate
  always_comb begin
    cand_ok_o = 1'b0;
    cand_o    = CODE_NONE;
    if (hits == 5'd1) begin
      cand_ok_o = 1'b1;
      cand_o    = hit_code;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning driver for a 4x4 matrix keypad with scan-level debounce.
// One column is pulled low at a time; rows are read back through a
// synchronizer at the end of each column's dwell, assembled into a full-pad
// snapshot, and the snapshot is debounced over whole scans before a key
// press or release is accepted.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW_W  = $clog2(SCAN_CYCLES);
  // The confirm counter only ever holds 1..DEBOUNCE_SCANS-1; reaching the
  // threshold leaves the confirm state instead of being stored.
  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_SCANS - 1);

  // Row synchronizer
  logic [3:0]      row_meta_q;
  logic [3:0]      row_sync_q;

  // Scan timing and snapshot assembly
  logic [DW_W-1:0] dwell_q,   dwell_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [3:0]      col_q,     col_d;
  logic [15:0]     acc_q,     acc_d;
  logic [15:0]     snap_q,    snap_d;
  logic            commit_q,  commit_d;

  // Decoded candidate for the most recently committed scan
  logic            cand_ok;
  logic [3:0]      cand;

  // Debounce FSM state and registered outputs
  state_e          state_q;
  logic [3:0]      cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]      key_code_q;
  logic            key_valid_q;
  logic            key_held_q;

  logic            last_dwell;
  logic            same_cand;
  logic            same_key;

  assign last_dwell = (dwell_q == DWELL_LAST);

  // Two-stage synchronizer: the rows are driven by mechanical switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= ROW_IDLE;
      row_sync_q <= ROW_IDLE;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  // Next-state for dwell counter, column rotation and snapshot capture.
  // Rows are read on the last dwell cycle so the column has had the whole
  // dwell plus the synchronizer delay to settle.
  always_comb begin
    dwell_d   = dwell_q + DW_W'(1);
    col_idx_d = col_idx_q;
    col_d     = col_q;
    acc_d     = acc_q;
    snap_d    = snap_q;
    commit_d  = 1'b0;
    if (last_dwell) begin
      dwell_d   = '0;
      col_idx_d = col_idx_q + 2'd1;
      col_d     = {col_q[2:0], col_q[3]};
      acc_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
      if (col_idx_q == 2'd3) begin
        snap_d   = acc_d;
        commit_d = 1'b1;
      end
    end
  end

  // Scan state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q   <= '0;
      col_idx_q <= 2'd0;
      col_q     <= COL_RESET;
      acc_q     <= '0;
      snap_q    <= '0;
      commit_q  <= 1'b0;
    end else begin
      dwell_q   <= dwell_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      acc_q     <= acc_d;
      snap_q    <= snap_d;
      commit_q  <= commit_d;
    end
  end

  keypad_decode u_decode (
    .snap_i    (snap_q),
    .cand_ok_o (cand_ok),
    .cand_o    (cand)
  );

  assign same_cand = cand_ok && (cand == cand_q);
  assign same_key  = cand_ok && (cand == key_code_q);

  // Debounce FSM: moves only on the cycle after a full-scan commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cand_q      <= CODE_NONE;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (commit_q) begin
        unique case (state_q)
          ST_IDLE: begin
            if (cand_ok) begin
              cand_q <= cand;
              if (DEBOUNCE_SCANS == 1) begin
                state_q     <= ST_PRESSED;
                key_code_q  <= cand;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= '0;
              end else begin
                state_q <= ST_CONFIRM_PRESS;
                cnt_q   <= CNT_W'(1);
              end
            end
          end

          ST_CONFIRM_PRESS: begin
            if (same_cand) begin
              if (cnt_q == CNT_LAST) begin
                state_q     <= ST_PRESSED;
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end
          end

          ST_PRESSED: begin
            // A second key joining in decodes as no-candidate, which starts
            // a release; this is what blocks rollover from emitting a press.
            if (!same_key) begin
              if (DEBOUNCE_SCANS == 1) begin
                state_q    <= ST_IDLE;
                key_held_q <= 1'b0;
                cnt_q      <= '0;
              end else begin
                state_q <= ST_CONFIRM_RELEASE;
                cnt_q   <= CNT_W'(1);
              end
            end
          end

          ST_CONFIRM_RELEASE: begin
            if (same_key) begin
              state_q <= ST_PRESSED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q    <= ST_IDLE;
              key_held_q <= 1'b0;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix model.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Closed switches, bit index = col*4 + row
  logic [15:0] keys = 16'h0;

  int         tests = 0;
  int         fails = 0;
  int         vcount = 0;
  logic [3:0] last_code = 4'h0;

  keypad_scanner #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Matrix model: a closed switch pulls its row low while its column is low
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
  end

  // Pulse counter and one-column-low invariant
  always @(negedge clk) begin
    if (key_valid) begin
      vcount++;
      last_code = key_code;
    end
    tests++;
    if (!$onehot(~col)) begin
      fails++;
      $display("FAIL col_onehot: col=%b, required exactly one bit low", col);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [3:0] exp_col [5];
    exp_col = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst_n = 1'b0;
    keys  = 16'h0;
    cycles(3);
    tests++; if (col !== 4'b1110) begin fails++; $display("FAIL reset_col: got %b want 1110", col); end
    tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_code: got %h want 0", key_code); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL reset_held: got %b want 0", key_held); end
    rst_n = 1'b1;
    cycles(2);
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (col !== exp_col[k]) begin
        fails++;
        $display("FAIL col_seq[%0d]: got %b want %b", k, col, exp_col[k]);
      end
      cycles(4);
    end
  endtask

  task automatic test_idle;
    int v0;
    v0 = vcount;
    cycles(64);
    tests++; if (vcount != v0) begin fails++; $display("FAIL idle_no_valid: got %0d pulses want 0", vcount - v0); end
  endtask

  task automatic test_single_key;
    int v0;
    v0 = vcount;
    keys = 16'h0001 << 9;   // r1,c2 -> '6'
    cycles(80);
    tests++; if (vcount - v0 != 1) begin fails++; $display("FAIL single_count: got %0d pulses want 1", vcount - v0); end
    tests++; if (last_code !== 4'h6) begin fails++; $display("FAIL single_code: got %h want 6", last_code); end
    tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL single_held: got %b want 1", key_held); end
    keys = 16'h0;
    cycles(8);
    tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL release_early: got held=%b want 1", key_held); end
    cycles(56);
    tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL release_held: got %b want 0", key_held); end
    tests++; if (key_code !== 4'h6) begin fails++; $display("FAIL release_code: got %h want 6", key_code); end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = vcount;
    for (int i = 0; i < 2; i++) begin
      keys = 16'h0001 << 7;   // r3,c1 -> 'F'
      cycles(16);
      keys = 16'h0;
      cycles(16);
    end
    tests++; if (vcount != v0) begin fails++; $display("FAIL glitch_early: got %0d pulses want 0", vcount - v0); end
    keys = 16'h0001 << 7;
    cycles(80);
    tests++; if (vcount - v0 != 1) begin fails++; $display("FAIL glitch_count: got %0d pulses want 1", vcount - v0); end
    tests++; if (last_code !== 4'hF) begin fails++; $display("FAIL glitch_code: got %h want F", last_code); end
    tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL glitch_held: got %b want 1", key_held); end
    keys = 16'h0;
    cycles(64);
  endtask

  task automatic test_rollover;
    int v0;
    v0 = vcount;
    keys = 16'h0001;        // r0,c0 -> '1'
    cycles(64);
    tests++; if (vcount - v0 != 1) begin fails++; $display("FAIL roll_first_count: got %0d want 1", vcount - v0); end
    tests++; if (last_code !== 4'h1) begin fails++; $display("FAIL roll_first_code: got %h want 1", last_code); end
    v0 = vcount;
    keys = keys | (16'h0001 << 14);   // add r2,c3 -> 'C'
    cycles(80);
    tests++; if (vcount != v0) begin fails++; $display("FAIL roll_second: got %0d pulses want 0", vcount - v0); end
    tests++; if (key_code !== 4'h1) begin fails++; $display("FAIL roll_code_kept: got %h want 1", key_code); end
    keys = 16'h0;
    cycles(48);
    keys = 16'h0001 << 14;
    cycles(64);
    tests++; if (vcount - v0 != 1) begin fails++; $display("FAIL roll_c_count: got %0d want 1", vcount - v0); end
    tests++; if (key_code !== 4'hC) begin fails++; $display("FAIL roll_c_code: got %h want C", key_code); end
    keys = 16'h0;
    cycles(64);
  endtask

  task automatic test_short_press;
    int v0;
    v0 = vcount;
    keys = 16'h0001 << 12;  // r0,c3 -> 'A'
    cycles(16);
    keys = 16'h0;
    cycles(64);
    tests++; if (vcount != v0) begin fails++; $display("FAIL short_valid: got %0d pulses want 0", vcount - v0); end
    tests++; if (key_code !== 4'hC) begin fails++; $display("FAIL short_code: got %h want C", key_code); end
  endtask

  task automatic test_reset_mid_confirm;
    int v0;
    int n;
    n = 0;
    while (col !== 4'b0111 && n < 64) begin @(negedge clk); n++; end
    while (col !== 4'b1110 && n < 128) begin @(negedge clk); n++; end
    tests++;
    if (n >= 128) begin fails++; $display("FAIL align_timeout: col=%b never reached 1110", col); end
    keys = 16'h0001 << 10;  // r2,c2 -> '9'
    cycles(20);
    v0 = vcount;
    rst_n = 1'b0;
    #1;
    tests++; if (col !== 4'b1110) begin fails++; $display("FAIL rst_mid_col: got %b want 1110", col); end
    tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL rst_mid_code: got %h want 0", key_code); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", key_valid); end
    tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL rst_mid_held: got %b want 0", key_held); end
    tests++; if (vcount != v0) begin fails++; $display("FAIL rst_mid_prior: got %0d pulses want 0", vcount - v0); end
    cycles(3);
    rst_n = 1'b1;
    cycles(24);
    tests++; if (vcount != v0) begin fails++; $display("FAIL rst_fresh_early: got %0d pulses want 0", vcount - v0); end
    tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL rst_fresh_code0: got %h want 0", key_code); end
    cycles(16);
    tests++; if (vcount - v0 != 1) begin fails++; $display("FAIL rst_fresh_count: got %0d want 1", vcount - v0); end
    tests++; if (last_code !== 4'h9) begin fails++; $display("FAIL rst_fresh_code: got %h want 9", last_code); end
    tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL rst_fresh_held: got %b want 1", key_held); end
    keys = 16'h0;
    cycles(64);
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_idle();
    test_single_key();
    test_glitch();
    test_rollover();
    test_short_press();
    test_reset_mid_confirm();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
